// File: rtl/alu_src_sel_pipe.sv
// ALU operand-source selector: picks one of NUM_IN candidates and buffers it in a 2-entry skid stage.
// Optional sticky out-of-range select flag enabled by defining ALU_SRC_SEL_ERR_EN.
module alu_src_sel_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [1:0]              occupancy,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] out_data_p1;
  logic [WIDTH-1:0] skid_p1;
  logic [WIDTH-1:0] sel_val_p0;
  logic             accept, consume;
  logic             load_out, load_skid, move_skid;

  // Out-of-range indices fall through the loop and yield all-zeros.
  function automatic logic [WIDTH-1:0] pick(input logic [NUM_IN*WIDTH-1:0] bus,
                                            input logic [SEL_W-1:0] s);
    pick = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (s == SEL_W'(i)) pick = bus[i*WIDTH +: WIDTH];
    end
  endfunction

  assign sel_val_p0 = pick(data_in, sel);
  assign in_ready   = (state != FULL);
  assign out_valid  = (state != EMPTY);
  assign occupancy  = state;
  assign out_data   = out_data_p1;
  assign accept     = in_valid & in_ready;
  assign consume    = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nx = ONE;
          load_out = 1'b1;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_nx  = FULL;
          load_skid = 1'b1;
        end else if (consume) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          state_nx  = ONE;
          move_skid = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // ---- stage p0 -> p1: operand registers, written only on accepted data or skid drain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_p1 <= '0;
      skid_p1     <= '0;
    end else begin
      if (load_out)       out_data_p1 <= sel_val_p0;
      else if (move_skid) out_data_p1 <= skid_p1;
      if (load_skid)      skid_p1     <= sel_val_p0;
    end
  end

`ifdef ALU_SRC_SEL_ERR_EN
  logic sel_oor;
  logic sel_err_p1;

  assign sel_oor = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               sel_err_p1 <= 1'b0;
    else if (accept && sel_oor) sel_err_p1 <= 1'b1;
  end

  assign sel_err = sel_err_p1;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_src_sel_pipe.sv
// Bench for alu_src_sel_pipe: queue-based reference model checked every cycle plus directed literal checks.
module tb_alu_src_sel_pipe;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [1:0]              sel = '0;
  logic [NUM_IN*WIDTH-1:0] data_in = {32'd2, 32'd1, 32'd0};
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [WIDTH-1:0]        out_data;
  logic [1:0]              occupancy;
  logic                    sel_err;

  int tests = 0;
  int fails = 0;

  alu_src_sel_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

`ifdef ALU_SRC_SEL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // Reference: a FIFO of at most two selected operands plus a sticky flag.
  logic [WIDTH-1:0] q[$];
  bit               m_err = 1'b0;
  bit               m_acc, m_con;

  function automatic logic [WIDTH-1:0] ref_pick(input logic [NUM_IN*WIDTH-1:0] bus, input int s);
    if (s < NUM_IN) return bus[s*WIDTH +: WIDTH];
    return '0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      m_acc = in_valid && (q.size() < 2);
      m_con = (q.size() > 0) && out_ready;
      if (m_con) void'(q.pop_front());
      if (m_acc) begin
        q.push_back(ref_pick(data_in, int'(sel)));
        if (int'(sel) >= NUM_IN) m_err = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_occ",   64'(occupancy), 64'(q.size()));
      chk("m_oval",  64'(out_valid), 64'(q.size() > 0));
      chk("m_irdy",  64'(in_ready),  64'(q.size() < 2));
      chk("m_err",   64'(sel_err),   64'(ERR_EN & m_err));
      if (q.size() > 0) chk("m_data", 64'(out_data), 64'(q[0]));
    end
  end

  task automatic step(input bit iv, input logic [1:0] s, input bit ordy);
    in_valid  = iv;
    sel       = s;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oval", 64'(out_valid), 64'd0);
    chk("rst_irdy", 64'(in_ready),  64'd1);
    chk("rst_occ",  64'(occupancy), 64'd0);
    chk("rst_data", 64'(out_data),  64'd0);
    chk("rst_err",  64'(sel_err),   64'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Back-to-back flow with out_ready high
    step(1, 2'd0, 1);
    chk("b2b_d0", 64'(out_data), 64'd0);
    chk("b2b_v0", 64'(out_valid), 64'd1);
    step(1, 2'd1, 1);
    chk("b2b_d1", 64'(out_data), 64'd1);
    chk("b2b_r1", 64'(in_ready), 64'd1);
    step(1, 2'd2, 1);
    chk("b2b_d2", 64'(out_data), 64'd2);
    chk("b2b_o2", 64'(occupancy), 64'd1);
    step(0, 2'd0, 1);
    chk("b2b_drain", 64'(occupancy), 64'd0);

    // Stall fills skid, third offer refused, then drain in order
    step(1, 2'd1, 0);
    chk("stl_o1", 64'(occupancy), 64'd1);
    step(1, 2'd2, 0);
    chk("stl_o2", 64'(occupancy), 64'd2);
    chk("stl_rdy", 64'(in_ready), 64'd0);
    chk("stl_d1", 64'(out_data), 64'd1);
    step(1, 2'd0, 0);
    chk("stl_hold_o", 64'(occupancy), 64'd2);
    chk("stl_hold_d", 64'(out_data), 64'd1);
    step(0, 2'd0, 1);
    chk("stl_dr_d2", 64'(out_data), 64'd2);
    chk("stl_dr_o1", 64'(occupancy), 64'd1);
    step(0, 2'd0, 1);
    chk("stl_dr_o0", 64'(occupancy), 64'd0);

    // Simultaneous accept and consume at occupancy 1
    step(1, 2'd1, 0);
    step(1, 2'd2, 1);
    chk("ac_o1", 64'(occupancy), 64'd1);
    chk("ac_d2", 64'(out_data), 64'd2);
    step(0, 2'd0, 1);

    // Out-of-range select
    step(1, 2'd3, 1);
    chk("oor_d", 64'(out_data), 64'd0);
    chk("oor_v", 64'(out_valid), 64'd1);
    chk("oor_err", 64'(sel_err), 64'(ERR_EN));
    step(0, 2'd0, 1);
    step(0, 2'd0, 1);
    chk("oor_sticky", 64'(sel_err), 64'(ERR_EN));

    // Asynchronous reset while full
    step(1, 2'd1, 0);
    step(1, 2'd2, 0);
    chk("pre_rst_o", 64'(occupancy), 64'd2);
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("arst_o",    64'(occupancy), 64'd0);
    chk("arst_v",    64'(out_valid), 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_irdy", 64'(in_ready), 64'd1);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_err",  64'(sel_err),  64'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Random traffic against the queue model
    for (int i = 0; i < 10000; i++) begin
      data_in = {$urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    in_valid = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
